// File: rtl/nco_downmix_rx_pkg.sv
// Shared constants and types for the NCO down-mixing receiver.
package nco_downmix_rx_pkg;

  localparam int unsigned LUT_ADDR_W = 8;
  localparam logic [LUT_ADDR_W-1:0] COS_OFFSET = 8'd64;
  localparam logic [7:0] ADC_MIDSCALE = 8'd127;
  localparam int unsigned PROD_W = 16;

  typedef logic signed [PROD_W-1:0] prod_t;

  // Offset-binary ADC code to signed sample; code 255 (+128) clamps to +127.
  function automatic logic signed [7:0] to_signed_sample(input logic [7:0] code);
    logic signed [8:0] d;
    d = $signed({1'b0, code}) - $signed({1'b0, ADC_MIDSCALE});
    if (d > 9'sd127) return 8'sd127;
    return d[7:0];
  endfunction

endpackage

// File: rtl/nco_phase_acc.sv
// NCO phase accumulator with per-sample clear; exposes the LUT address of the current sample.
module nco_phase_acc
  import nco_downmix_rx_pkg::*;
#(
  parameter int unsigned PHASE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  advance,
  input  logic                  clear,
  input  logic [PHASE_W-1:0]    freq_word,
  output logic [LUT_ADDR_W-1:0] lut_addr
);

  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] phase;

  assign phase    = clear ? '0 : acc;
  assign lut_addr = phase[PHASE_W-1 -: LUT_ADDR_W];

  always_ff @(posedge clk) begin
    if (rst)          acc <= '0;
    else if (advance) acc <= phase + freq_word;
    else if (clear)   acc <= '0;
  end

endmodule

// File: rtl/sine_lookup.sv
// Quarter-wave sine ROM shared with the TX path: round(127*sin(2*pi*addr/256)).
module sine_lookup (
  input  logic [7:0]        addr,
  output logic signed [7:0] data
);

  function automatic logic [6:0] quarter(input logic [6:0] i);
    case (i)
      7'd0:  return 7'd0;   7'd1:  return 7'd3;   7'd2:  return 7'd6;   7'd3:  return 7'd9;
      7'd4:  return 7'd12;  7'd5:  return 7'd16;  7'd6:  return 7'd19;  7'd7:  return 7'd22;
      7'd8:  return 7'd25;  7'd9:  return 7'd28;  7'd10: return 7'd31;  7'd11: return 7'd34;
      7'd12: return 7'd37;  7'd13: return 7'd40;  7'd14: return 7'd43;  7'd15: return 7'd46;
      7'd16: return 7'd49;  7'd17: return 7'd51;  7'd18: return 7'd54;  7'd19: return 7'd57;
      7'd20: return 7'd60;  7'd21: return 7'd63;  7'd22: return 7'd65;  7'd23: return 7'd68;
      7'd24: return 7'd71;  7'd25: return 7'd73;  7'd26: return 7'd76;  7'd27: return 7'd78;
      7'd28: return 7'd81;  7'd29: return 7'd83;  7'd30: return 7'd85;  7'd31: return 7'd88;
      7'd32: return 7'd90;  7'd33: return 7'd92;  7'd34: return 7'd94;  7'd35: return 7'd96;
      7'd36: return 7'd98;  7'd37: return 7'd100; 7'd38: return 7'd102; 7'd39: return 7'd104;
      7'd40: return 7'd106; 7'd41: return 7'd107; 7'd42: return 7'd109; 7'd43: return 7'd111;
      7'd44: return 7'd112; 7'd45: return 7'd113; 7'd46: return 7'd115; 7'd47: return 7'd116;
      7'd48: return 7'd117; 7'd49: return 7'd118; 7'd50: return 7'd120; 7'd51: return 7'd121;
      7'd52: return 7'd122; 7'd53: return 7'd122; 7'd54: return 7'd123; 7'd55: return 7'd124;
      7'd56: return 7'd125; 7'd57: return 7'd125; 7'd58: return 7'd126; 7'd59: return 7'd126;
      7'd60: return 7'd126; default: return 7'd127;
    endcase
  endfunction

  logic [6:0] idx;
  logic [6:0] mag;

  always_comb begin
    idx = addr[6] ? (7'd64 - {1'b0, addr[5:0]}) : {1'b0, addr[5:0]};
    mag = quarter(idx);
    data = addr[7] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  end

endmodule

// File: rtl/nco_downmix_rx.sv
// NCO down-mixer with integrate-and-dump I/Q and valid/ready output.
// Define DOWNMIX_SAT_EN for saturating accumulators (default wraps).
module nco_downmix_rx
  import nco_downmix_rx_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned PHASE_W = 16,
  parameter int unsigned ACC_W   = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       sample_in,
  input  logic                    sample_valid,
  input  logic [PHASE_W-1:0]      freq_word,
  input  logic                    phase_clear,
  input  logic [7:0]              dump_len,
  output logic signed [ACC_W-1:0] i_out,
  output logic signed [ACC_W-1:0] q_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun
);

  function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] a,
                                                      input prod_t p);
`ifdef DOWNMIX_SAT_EN
    logic signed [ACC_W:0] s;
    s = $signed({a[ACC_W-1], a}) + $signed({{(ACC_W+1-PROD_W){p[PROD_W-1]}}, p});
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return s[ACC_W-1:0];
`else
    return a + $signed({{(ACC_W-PROD_W){p[PROD_W-1]}}, p});
`endif
  endfunction

  logic [LUT_ADDR_W-1:0] nco_addr, addr0, cos_addr;
  logic signed [7:0]     x0, x1, sin_w, cos_w, sin1, cos1;
  logic                  v0, v1, v2;
  prod_t                 prod_i, prod_q;

  logic signed [ACC_W-1:0] i_acc, q_acc, i_next, q_next;
  logic [8:0]              count, len_q, eff_len;
  logic                    first, done;

  nco_phase_acc #(.PHASE_W(PHASE_W)) u_nco (
    .clk       (clk),
    .rst       (rst),
    .advance   (sample_valid),
    .clear     (phase_clear),
    .freq_word (freq_word),
    .lut_addr  (nco_addr)
  );

  assign cos_addr = addr0 + COS_OFFSET;

  sine_lookup u_sin (.addr(addr0),    .data(sin_w));
  sine_lookup u_cos (.addr(cos_addr), .data(cos_w));

  always_ff @(posedge clk) begin
    if (rst) begin
      v0 <= 1'b0; v1 <= 1'b0; v2 <= 1'b0;
      x0 <= '0; addr0 <= '0; x1 <= '0; sin1 <= '0; cos1 <= '0;
      prod_i <= '0; prod_q <= '0;
    end else begin
      v0 <= sample_valid;
      if (sample_valid) begin
        x0    <= to_signed_sample(sample_in);
        addr0 <= nco_addr;
      end
      v1 <= v0;
      if (v0) begin
        x1   <= x0;
        sin1 <= sin_w;
        cos1 <= cos_w;
      end
      v2 <= v1;
      if (v1) begin
        prod_i <= x1 * cos1;
        prod_q <= x1 * sin1;
      end
    end
  end

  // The first sample of a dump uses dump_len live; later samples use the latched copy.
  always_comb begin
    first   = (count == 9'd0);
    eff_len = first ? ((dump_len == 8'd0) ? 9'd256 : {1'b0, dump_len}) : len_q;
    done    = v2 && (count + 9'd1 == eff_len);
    i_next  = acc_add(i_acc, prod_i);
    q_next  = acc_add(q_acc, prod_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_acc <= '0; q_acc <= '0; count <= '0; len_q <= '0;
      i_out <= '0; q_out <= '0; out_valid <= 1'b0; overrun <= 1'b0;
    end else begin
      if (v2) begin
        if (first) len_q <= eff_len;
        if (done) begin
          i_acc <= '0;
          q_acc <= '0;
          count <= '0;
        end else begin
          i_acc <= i_next;
          q_acc <= q_next;
          count <= count + 9'd1;
        end
      end
      if (done) begin
        i_out     <= i_next;
        q_out     <= q_next;
        out_valid <= 1'b1;
        if (out_valid && !out_ready) overrun <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nco_downmix_rx.sv
// Self-checking bench for nco_downmix_rx against a trigonometric reference model.
module tb_nco_downmix_rx;

  logic               clk = 1'b0;
  logic               rst;
  logic [7:0]         sample_in;
  logic               sample_valid;
  logic [15:0]        freq_word;
  logic               phase_clear;
  logic [7:0]         dump_len;
  logic signed [23:0] i_out;
  logic signed [23:0] q_out;
  logic               out_valid;
  logic               out_ready;
  logic               overrun;

  int errors = 0;
  int checks = 0;

  typedef struct { bit v; int code; bit clr; } stim_t;
  stim_t stim[$];
  int res_i[$], res_q[$], exp_i[$], exp_q[$];

  nco_downmix_rx #(.DATA_W(8), .PHASE_W(16), .ACC_W(24)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .freq_word    (freq_word),
    .phase_clear  (phase_clear),
    .dump_len     (dump_len),
    .i_out        (i_out),
    .q_out        (q_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  function automatic int conv(input int code);
    int x = code - 127;
    return (x > 127) ? 127 : x;
  endfunction

  function automatic int lut(input int a);
    real r = 127.0 * $sin(2.0 * 3.14159265358979 * a / 256.0);
    return $rtoi(r + ((r >= 0.0) ? 0.5 : -0.5));
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; sample_valid = 1'b0; phase_clear = 1'b0; out_ready = 1'b0;
    sample_in = 8'd0;
    tick();
    rst = 1'b0;
  endtask

  // Expected dumps from the stimulus list: mix each accepted sample with the ideal NCO.
  task automatic model_seq(input int fw, input int dl);
    int ph = 0, cnt = 0, si = 0, sq = 0, p, a, x;
    int len = (dl == 0) ? 256 : dl;
    exp_i.delete(); exp_q.delete();
    foreach (stim[k]) begin
      if (stim[k].v) begin
        p  = stim[k].clr ? 0 : ph;
        ph = (p + fw) % 65536;
        a  = p / 256;
        x  = conv(stim[k].code);
        si += x * lut((a + 64) % 256);
        sq += x * lut(a);
        cnt++;
        if (cnt == len) begin
          exp_i.push_back(si); exp_q.push_back(sq);
          si = 0; sq = 0; cnt = 0;
        end
      end else if (stim[k].clr) begin
        ph = 0;
      end
    end
  endtask

  task automatic run_seq(input int drain);
    res_i.delete(); res_q.delete();
    out_ready = 1'b1;
    foreach (stim[k]) begin
      sample_valid = stim[k].v;
      sample_in    = 8'(stim[k].code);
      phase_clear  = stim[k].clr;
      tick();
      if (out_valid) begin res_i.push_back(int'(i_out)); res_q.push_back(int'(q_out)); end
    end
    sample_valid = 1'b0; phase_clear = 1'b0;
    for (int n = 0; n < drain; n++) begin
      tick();
      if (out_valid) begin res_i.push_back(int'(i_out)); res_q.push_back(int'(q_out)); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    sample_valid = 1'b1; sample_in = 8'd254; phase_clear = 1'b1; dump_len = 8'd1; freq_word = 16'd0;
    tick();
    sample_valid = 1'b0; phase_clear = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int n = 0; n < 5; n++) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (int'(i_out) !== 0) begin errors++; $display("FAIL reset_i got=%0d exp=0", i_out); end
    checks++; if (int'(q_out) !== 0) begin errors++; $display("FAIL reset_q got=%0d exp=0", q_out); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_dc_mix();
    do_reset();
    freq_word = 16'd0; dump_len = 8'd4;
    for (int n = 0; n < 4; n++) begin
      sample_valid = 1'b1; sample_in = 8'd254; phase_clear = (n == 0);
      tick();
    end
    sample_valid = 1'b0; phase_clear = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dc_early_valid got=%b exp=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dc_valid_latency got=%b exp=1", out_valid); end
    checks++; if (int'(i_out) !== 64516) begin errors++; $display("FAIL dc_i got=%0d exp=64516", i_out); end
    checks++; if (int'(q_out) !== 0) begin errors++; $display("FAIL dc_q got=%0d exp=0", q_out); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dc_hold got=%b exp=1", out_valid); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dc_take got=%b exp=0", out_valid); end
  endtask

  task automatic test_midscale();
    do_reset();
    freq_word = 16'($urandom); dump_len = 8'd8;
    stim.delete();
    for (int n = 0; n < 16; n++) stim.push_back('{1'b1, 127, n == 0});
    run_seq(6);
    checks++; if (res_i.size() !== 2) begin errors++; $display("FAIL mid_count got=%0d exp=2", res_i.size()); end
    foreach (res_i[k]) begin
      checks++;
      if (res_i[k] !== 0 || res_q[k] !== 0) begin
        errors++; $display("FAIL mid_value[%0d] got=%0d/%0d exp=0/0", k, res_i[k], res_q[k]);
      end
    end
  endtask

  task automatic test_clamp();
    int codes[2] = '{255, 0};
    int want[2]  = '{64516, -64516};
    for (int c = 0; c < 2; c++) begin
      do_reset();
      freq_word = 16'd0; dump_len = 8'd4;
      stim.delete();
      for (int n = 0; n < 4; n++) stim.push_back('{1'b1, codes[c], n == 0});
      run_seq(6);
      checks++;
      if (res_i.size() !== 1 || res_i[0] !== want[c] || res_q[0] !== 0) begin
        errors++;
        $display("FAIL clamp_code%0d got n=%0d i=%0d exp n=1 i=%0d q=0", codes[c], res_i.size(),
                 (res_i.size() > 0) ? res_i[0] : 0, want[c]);
      end
    end
  endtask

  task automatic test_overrun();
    int codes[4] = '{200, 200, 100, 100};
    do_reset();
    freq_word = 16'd0; dump_len = 8'd2;
    for (int n = 0; n < 4; n++) begin
      sample_valid = 1'b1; sample_in = 8'(codes[n]); phase_clear = (n == 0);
      tick();
    end
    sample_valid = 1'b0; phase_clear = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early got=%b exp=0", overrun); end
    for (int n = 0; n < 4; n++) tick();
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got=%b exp=1", overrun); end
    checks++; if (int'(i_out) !== -6858) begin errors++; $display("FAIL ovr_i got=%0d exp=-6858", i_out); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovr_take got=%b exp=0", out_valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
    checks++; if (int'(i_out) !== -6858) begin errors++; $display("FAIL ovr_hold got=%0d exp=-6858", i_out); end
  endtask

  task automatic test_bubbles();
    do_reset();
    freq_word = 16'h1234; dump_len = 8'd2;
    stim.delete();
    for (int n = 0; n < 4; n++) begin
      stim.push_back('{1'b1, int'($urandom_range(255)), n == 0});
      stim.push_back('{1'b0, int'($urandom_range(255)), 1'b0});
    end
    model_seq(16'h1234, 2);
    run_seq(6);
    checks++; if (res_i.size() !== 2) begin errors++; $display("FAIL gap_count got=%0d exp=2", res_i.size()); end
    for (int k = 0; k < res_i.size() && k < 2; k++) begin
      checks++;
      if (res_i[k] !== exp_i[k] || res_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL gap_value[%0d] got=%0d/%0d exp=%0d/%0d", k, res_i[k], res_q[k], exp_i[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    freq_word = 16'd0; dump_len = 8'd4;
    for (int n = 0; n < 2; n++) begin
      sample_valid = 1'b1; sample_in = 8'd254; phase_clear = (n == 0);
      tick();
    end
    sample_valid = 1'b0; phase_clear = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    stim.delete();
    for (int n = 0; n < 4; n++) stim.push_back('{1'b1, 254, n == 0});
    run_seq(6);
    checks++;
    if (res_i.size() !== 1 || res_i[0] !== 64516 || res_q[0] !== 0) begin
      errors++;
      $display("FAIL midrst got n=%0d i=%0d exp n=1 i=64516", res_i.size(), (res_i.size() > 0) ? res_i[0] : 0);
    end
  endtask

  task automatic test_random();
    int fw, dl;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      fw = int'($urandom_range(65535)); dl = int'($urandom_range(6, 1));
      freq_word = 16'(fw); dump_len = 8'(dl);
      stim.delete();
      for (int n = 0; n < 48; n++)
        stim.push_back('{($urandom_range(3) != 0), int'($urandom_range(255)), n == 0});
      stim[0].v = 1'b1;
      model_seq(fw, dl);
      run_seq(8);
      checks++;
      if (res_i.size() !== exp_i.size()) begin
        errors++; $display("FAIL rand%0d_count got=%0d exp=%0d", r, res_i.size(), exp_i.size());
      end
      for (int k = 0; k < res_i.size() && k < exp_i.size(); k++) begin
        checks++;
        if (res_i[k] !== exp_i[k] || res_q[k] !== exp_q[k]) begin
          errors++;
          $display("FAIL rand%0d_value[%0d] got=%0d/%0d exp=%0d/%0d", r, k, res_i[k], res_q[k], exp_i[k], exp_q[k]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; sample_in = 8'd0; sample_valid = 1'b0; freq_word = 16'd0;
    phase_clear = 1'b0; dump_len = 8'd4; out_ready = 1'b0;
    test_reset();
    test_dc_mix();
    test_midscale();
    test_clamp();
    test_overrun();
    test_bubbles();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
